// File: rtl/bclk_dpll.sv
// rtl/bclk_dpll.sv - bit-clock DPLL: locks to word clock wc, synthesizes BITS_PER_WORD bclk cycles per word
// Optional holdover on wc loss is enabled by defining BCLK_DPLL_HOLDOVER_EN.
module bclk_dpll #(
  parameter int CNT_W         = 12,
  parameter int BITS_PER_WORD = 64,
  parameter int PMIN          = 2000,
  parameter int PMAX          = 2600,
  parameter int TOL           = 2,
  parameter int LOCK_CNT      = 4
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             wc,
  output logic             bclk,
  output logic             error,
  output logic             locked,
  output logic             holdover,
  output logic [CNT_W-1:0] period
);

  localparam int STEP = 2 * BITS_PER_WORD;
  localparam int TC_W = $clog2(STEP + 1);
  localparam int GC_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] L_PMIN    = CNT_W'(PMIN);
  localparam logic [CNT_W-1:0] L_PMAX    = CNT_W'(PMAX);
  localparam logic [CNT_W-1:0] L_TMO     = CNT_W'(PMAX + 1);
  localparam logic [CNT_W-1:0] L_TOL     = CNT_W'(TOL);
  localparam logic [CNT_W:0]   L_STEP    = (CNT_W + 1)'(STEP);
  localparam logic [TC_W-1:0]  L_TC_END  = TC_W'(STEP);
  localparam logic [TC_W-1:0]  L_TC_LAST = TC_W'(STEP - 1);
  localparam logic [GC_W-1:0]  L_LOCK    = GC_W'(LOCK_CNT);

  if ((4 * BITS_PER_WORD > PMIN) || (PMAX >= (2 ** CNT_W) - 1)) begin : g_bad_params
    $error("bclk_dpll: need 4*BITS_PER_WORD <= PMIN and PMAX < 2**CNT_W-1");
  end

  typedef enum logic [1:0] {
    S_UNLOCK   = 2'd0,
    S_ACQUIRE  = 2'd1,
    S_LOCKED   = 2'd2,
    S_HOLDOVER = 2'd3
  } state_t;

  logic             r_sync1, r_sync2, r_sync3;
  logic [1:0]       r_fill;
  logic             r_wc_rise;
  logic [CNT_W-1:0] r_pcnt;
  state_t           r_state;
  logic [GC_W-1:0]  r_good_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_error;
  logic [CNT_W:0]   r_acc;
  logic [TC_W-1:0]  r_tcnt;
  logic             r_bclk;

  state_t           w_state_nxt;
  logic [GC_W-1:0]  w_good_nxt;
  logic [GC_W-1:0]  w_gc_inc;
  logic [CNT_W-1:0] w_period_nxt;
  logic             w_error_nxt;
  logic             w_realign;
  logic             w_in_range;
  logic [CNT_W-1:0] w_dev;
  logic             w_good;
  logic             w_timeout;
  logic [CNT_W:0]   w_sum;
  logic             w_hit;
  logic             w_gen;

  // r_fill masks edges until the pipeline holds real wc samples, so a level present at release is not a rise
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_fill    <= 2'd0;
      r_wc_rise <= 1'b0;
    end else begin
      r_sync1   <= wc;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
      r_wc_rise <= r_sync2 & ~r_sync3 & (r_fill == 2'd3);
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
    end else if (r_wc_rise) begin
      r_pcnt <= CNT_W'(1);
    end else if (r_pcnt != '1) begin
      r_pcnt <= r_pcnt + CNT_W'(1);
    end
  end

  assign w_in_range = (r_pcnt >= L_PMIN) && (r_pcnt <= L_PMAX);
  assign w_dev      = (r_pcnt >= r_period) ? (r_pcnt - r_period) : (r_period - r_pcnt);
  assign w_good     = w_in_range && ((r_good_cnt == '0) || (w_dev <= L_TOL));
  assign w_timeout  = (r_pcnt == L_TMO) && !r_wc_rise;
  assign w_gc_inc   = r_good_cnt + GC_W'(1);
  assign w_sum      = r_acc + L_STEP;
  assign w_hit      = (r_tcnt != L_TC_END) && (w_sum >= {1'b0, r_period});

  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good_cnt;
    w_period_nxt = r_period;
    w_error_nxt  = 1'b0;
    w_realign    = 1'b0;
    case (r_state)
      S_UNLOCK: begin
        if (r_wc_rise) begin
          w_state_nxt = S_ACQUIRE;
          w_good_nxt  = '0;
        end
      end
      S_ACQUIRE: begin
        if (r_wc_rise) begin
          if (w_good) begin
            w_period_nxt = r_pcnt;
            w_good_nxt   = w_gc_inc;
            if (w_gc_inc == L_LOCK) begin
              w_state_nxt = S_LOCKED;
              w_realign   = 1'b1;
            end
          end else begin
            w_error_nxt = 1'b1;
            if (w_in_range) begin
              w_period_nxt = r_pcnt;
              w_good_nxt   = GC_W'(1);
            end else begin
              w_good_nxt = '0;
            end
          end
        end
      end
      S_LOCKED: begin
        if (r_wc_rise) begin
          if (w_good) begin
            w_period_nxt = r_pcnt;
            w_realign    = 1'b1;
          end else begin
            w_error_nxt = 1'b1;
            w_state_nxt = S_ACQUIRE;
            w_good_nxt  = '0;
          end
        end else if (w_timeout) begin
          w_error_nxt = 1'b1;
`ifdef BCLK_DPLL_HOLDOVER_EN
          w_state_nxt = S_HOLDOVER;
          w_realign   = 1'b1;
`else
          w_state_nxt = S_UNLOCK;
`endif
        end
      end
      S_HOLDOVER: begin
        if (r_wc_rise) begin
          w_state_nxt = S_ACQUIRE;
          w_good_nxt  = '0;
        end else if (w_hit && (r_tcnt == L_TC_LAST)) begin
          // the last toggle of a free-running word doubles as the word restart
          w_realign = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_UNLOCK;
        w_good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_UNLOCK;
      r_good_cnt <= '0;
      r_period   <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_period   <= w_period_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign w_gen = (w_state_nxt == S_LOCKED) || (w_state_nxt == S_HOLDOVER);

  // Fractional divider: each mclk adds 2*BITS_PER_WORD, every period's worth yields one bclk edge
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_tcnt <= '0;
      r_bclk <= 1'b0;
    end else if (!w_gen || w_realign) begin
      r_acc  <= '0;
      r_tcnt <= '0;
      r_bclk <= 1'b0;
    end else if (w_hit) begin
      r_acc  <= w_sum - {1'b0, r_period};
      r_tcnt <= r_tcnt + TC_W'(1);
      r_bclk <= ~r_bclk;
    end else if (r_tcnt != L_TC_END) begin
      r_acc <= w_sum;
    end
  end

  assign bclk   = r_bclk;
  assign error  = r_error;
  assign period = r_period;
  assign locked = (r_state == S_LOCKED);
`ifdef BCLK_DPLL_HOLDOVER_EN
  assign holdover = (r_state == S_HOLDOVER);
`else
  assign holdover = 1'b0;
`endif

endmodule

// File: tb/tb_bclk_dpll.sv
// tb/tb_bclk_dpll.sv - scoreboard bench for bclk_dpll with a word-level reference model
module tb_bclk_dpll;

  localparam int CNT_W    = 10;
  localparam int BPW      = 16;
  localparam int PMIN     = 200;
  localparam int PMAX     = 260;
  localparam int TOL      = 2;
  localparam int LOCK_CNT = 4;
  localparam int STEP     = 2 * BPW;
  localparam int NOM      = 227;
  localparam int M_UNL = 0, M_ACQ = 1, M_LCK = 2, M_HLD = 3;
`ifdef BCLK_DPLL_HOLDOVER_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic             mclk = 1'b0;
  logic             rst  = 1'b0;
  logic             wc   = 1'b0;
  logic             bclk, error, locked, holdover;
  logic [CNT_W-1:0] period;

  bclk_dpll #(
    .CNT_W(CNT_W), .BITS_PER_WORD(BPW), .PMIN(PMIN), .PMAX(PMAX), .TOL(TOL), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .mclk(mclk), .rst(rst), .wc(wc), .bclk(bclk), .error(error),
    .locked(locked), .holdover(holdover), .period(period)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    int due;
    bit err;
    bit lck;
    bit hld;
    int per;
    int tog;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_mode, m_streak, m_held, prev_gap, word_kind, word_pd;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // edges seen in a word of w mclk since realign with a held period pd; a high bclk is forced low at the end
  function automatic int exp_tog(input int w, input int pd);
    int n;
    n = (STEP * (w - 1)) / pd;
    if (n > STEP) n = STEP;
    return n + (n % 2);
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_reset();
    m_mode = M_UNL; m_streak = 0; m_held = 0; prev_gap = 0; word_kind = 0; word_pd = 0;
  endtask

  // wc rises now, then the next rise follows gap mclk later
  task automatic step(input int gap, input bit abort);
    exp_t e, t;
    int   meas;
    bit   in_rng, good;
    meas   = prev_gap;
    e.due  = cyc + 4;
    e.err  = 1'b0;
    e.tog  = (word_kind == 1) ? exp_tog(meas, word_pd) : ((word_kind == 2) ? -1 : 0);
    in_rng = (meas >= PMIN) && (meas <= PMAX);
    good   = in_rng && ((m_streak == 0) || (absd(meas, m_held) <= TOL));
    case (m_mode)
      M_ACQ: begin
        if (good) begin
          m_held = meas;
          m_streak++;
          if (m_streak == LOCK_CNT) m_mode = M_LCK;
        end else begin
          e.err = 1'b1;
          if (in_rng) begin m_held = meas; m_streak = 1; end
          else m_streak = 0;
        end
      end
      M_LCK: begin
        if (good) m_held = meas;
        else begin e.err = 1'b1; m_mode = M_ACQ; m_streak = 0; end
      end
      default: begin m_mode = M_ACQ; m_streak = 0; end
    endcase
    e.lck = (m_mode == M_LCK);
    e.hld = (m_mode == M_HLD);
    e.per = m_held;
    sb_q.push_back(e);
    word_kind = (m_mode == M_LCK) ? 1 : 0;
    word_pd   = m_held;
    if (!abort && m_mode == M_LCK && gap > PMAX + 1) begin
      t.due = e.due + PMAX + 1; t.err = 1'b1; t.lck = 1'b0; t.hld = HOLD_EN;
      t.per = m_held; t.tog = exp_tog(PMAX + 1, m_held);
      sb_q.push_back(t);
      if (HOLD_EN) begin
        m_mode = M_HLD; word_kind = 2;
        for (int k = 1; t.due + k * m_held < e.due + gap; k++) begin
          exp_t h;
          h.due = t.due + k * m_held; h.err = 1'b0; h.lck = 1'b0; h.hld = 1'b1;
          h.per = m_held; h.tog = STEP;
          sb_q.push_back(h);
        end
      end else begin
        m_mode = M_UNL; word_kind = 0;
      end
    end
    wc = 1'b1;
    if (abort) begin
      repeat (10) @(negedge mclk);
      for (int i = 0; i < 200 && bclk !== 1'b1; i++) @(negedge mclk);
      check("bclk_high_before_reset", int'(bclk), 1);
      #1 rst = 1'b0;
      #1;
      check("midword_rst_bclk", int'(bclk), 0);
      check("midword_rst_locked", int'(locked), 0);
      check("midword_rst_error", int'(error), 0);
      check("midword_rst_period", int'(period), 0);
      sb_q.delete();
      model_reset();
      repeat (3) @(negedge mclk);
      rst = 1'b1;
      repeat (20) @(negedge mclk);
      wc = 1'b0;
      repeat (20) @(negedge mclk);
    end else begin
      repeat (gap / 2) @(negedge mclk);
      wc = 1'b0;
      repeat (gap - gap / 2) @(negedge mclk);
      prev_gap = gap;
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit   prev_b;
    int   tog;
    prev_b = 1'b0;
    tog    = 0;
    forever begin
      @(negedge mclk);
      if (!rst) begin
        tog    = 0;
        prev_b = 1'b0;
      end else begin
        if (bclk !== prev_b) tog++;
        prev_b = bclk;
        if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
          e = sb_q.pop_front();
          check("event_missed_due", cyc, e.due);
        end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
          e = sb_q.pop_front();
          check("error_pulse", int'(error), int'(e.err));
          check("locked", int'(locked), int'(e.lck));
          check("holdover", int'(holdover), int'(e.hld));
          check("period", int'(period), e.per);
          if (e.tog >= 0) check("bclk_edges_per_word", tog, e.tog);
          tog = 0;
        end else if (error) begin
          check("spurious_error", int'(error), 0);
        end
      end
    end
  end

  initial begin : stimulus
    int base, g;
    model_reset();
    repeat (3) @(negedge mclk);
    check("reset_bclk", int'(bclk), 0);
    check("reset_error", int'(error), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_holdover", int'(holdover), 0);
    check("reset_period", int'(period), 0);
    rst = 1'b1;
    repeat (10) @(negedge mclk);

    repeat (6) step(NOM, 1'b0);
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? NOM - 1 : NOM + 1, 1'b0);
    repeat (5) step(NOM + 7, 1'b0);
    step(150, 1'b0);
    repeat (6) step(NOM, 1'b0);
    step(PMAX + 1, 1'b0);
    repeat (6) step(PMAX, 1'b0);
    repeat (6) step(PMIN, 1'b0);
    step(1000, 1'b0);
    repeat (6) step(NOM, 1'b0);

    base = NOM;
    repeat (50) begin
      if ($urandom_range(0, 7) == 0) begin
        g = int'($urandom_range(180, 280));
      end else begin
        base = base + int'($urandom_range(0, 4)) - 2;
        if (base < PMIN + 5) base = PMIN + 5;
        if (base > PMAX - 5) base = PMAX - 5;
        g = base;
      end
      step(g, 1'b0);
    end

    repeat (6) step(NOM, 1'b0);
    step(NOM, 1'b1);
    repeat (7) step(NOM, 1'b0);

    repeat (10) @(negedge mclk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bclk_dpll.md
BCLK_DPLL -- requirements
Module: bclk_dpll

Interface
REQ-001 SHALL have parameter CNT_W, default 12, width of the period counter and period output.
REQ-002 SHALL have parameter BITS_PER_WORD, default 64, bclk cycles generated per wc period.
REQ-003 SHALL have parameters PMIN/PMAX, defaults 2000/2600, inclusive legal wc period in mclk cycles.
REQ-004 SHALL have parameter TOL, default 2, maximum period-to-period deviation in mclk cycles.
REQ-005 SHALL have parameter LOCK_CNT, default 4, consecutive good measurements required to lock.
REQ-006 SHALL have ports: mclk in 1 sole clock, rising edge; rst in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: wc in 1 asynchronous word clock; bclk out 1 recovered bit clock; error out 1 fault pulse.
REQ-008 SHALL have ports: locked out 1; holdover out 1; period out CNT_W last accepted period.

Function
REQ-009 SHALL pass wc through a 2-flop synchronizer, then detect rising edges; wc_rise is a 1-cycle pulse 3 mclk after a wc rise.
REQ-010 SHALL count mclk in pcnt, set to 1 on wc_rise, otherwise increment, saturating at all-ones; meas = pcnt value before the wc_rise load.
REQ-011 SHALL define a good measurement as PMIN<=meas<=PMAX and |meas-period|<=TOL; the TOL check is skipped when good_cnt=0.
REQ-012 SHALL implement states UNLOCK, ACQUIRE, LOCKED, HOLDOVER; locked=1 only in LOCKED, holdover=1 only in HOLDOVER.
REQ-013 UNLOCK: first wc_rise -> ACQUIRE, good_cnt=0.
REQ-014 ACQUIRE: on wc_rise, good meas -> period<=meas, good_cnt+1, and -> LOCKED when good_cnt reaches LOCK_CNT; bad meas -> 1-cycle error, good_cnt=1 if meas in [PMIN,PMAX] (period<=meas) else 0.
REQ-015 LOCKED: good meas -> period<=meas and realign; bad meas -> error, -> ACQUIRE with good_cnt=0.
REQ-016 LOCKED: pcnt reaching PMAX+1 without wc_rise -> error pulse, leaves LOCKED per REQ-025; wc_rise in the same cycle takes precedence and is judged per REQ-015.
REQ-017 SHALL generate bclk in LOCKED and HOLDOVER with accumulator acc (CNT_W+1 bits): each mclk acc+=2*BITS_PER_WORD; when the sum >=period, subtract period and toggle bclk.
REQ-018 SHALL stop toggling after 2*BITS_PER_WORD toggles within a word and hold bclk low until realign.
REQ-019 Realign (wc_rise in LOCKED, or word end in HOLDOVER) SHALL set acc=0, toggle count=0, bclk=0 in the same cycle.
REQ-020 bclk SHALL be held low in UNLOCK and ACQUIRE.
REQ-021 Parameters SHALL satisfy 4*BITS_PER_WORD<=PMIN and PMAX<2^CNT_W-1; violation is a compile-time error.

Reset
REQ-022 rst low SHALL immediately force UNLOCK, bclk=0, error=0, locked=0, holdover=0, period=0, pcnt=0, acc=0, good_cnt=0, synchronizer=0.
REQ-023 Reset asserted mid-word SHALL abort the word; after release no bclk edge before a full relock.
REQ-024 Release SHALL be taken on the next mclk edge; no wc_rise from a level present at release.

Configuration
REQ-025 Macro BCLK_DPLL_HOLDOVER_EN defined: timeout -> HOLDOVER, bclk free-runs from held period, word restarts each 2*BITS_PER_WORD toggles; wc_rise -> ACQUIRE, good_cnt=0; not defined: timeout -> UNLOCK, bclk low, HOLDOVER unreachable, holdover tied 0.

Verification
REQ-026 Reset release, wc period 2268 mclk -> locked=1 on the 5th wc_rise, period=2268, 128 bclk toggles per word, error never high.
REQ-027 Jitter 2267/2269 alternating, TOL=2 -> locked stays 1, no error; step to 2275 -> one error pulse, locked=0, relock after 4 good periods.
REQ-028 One short period 1500 while locked -> error pulse at that wc_rise, bclk low, ACQUIRE.
REQ-029 wc stopped while locked -> error pulse at pcnt=2601; macro on: holdover=1, bclk continues 128 toggles/2268 cycles; macro off: locked=0, bclk low.
REQ-030 rst low mid-word with bclk high -> bclk, locked, error, period all 0 before the next mclk edge.
